// File: rtl/tt_ihfaz_logic_pkg.sv
// Shared constants for the ihfaz logic unit: op encodings, uio field
// positions and the bitwise operation itself.
package tt_ihfaz_logic_pkg;

    localparam int unsigned OP_W     = 3;
    localparam int unsigned LANE_MAX = 4;

    localparam logic [OP_W-1:0] OP_NAND  = 3'b000;
    localparam logic [OP_W-1:0] OP_NOR   = 3'b001;
    localparam logic [OP_W-1:0] OP_AND   = 3'b010;
    localparam logic [OP_W-1:0] OP_OR    = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

    // uio_in field positions
    localparam int unsigned UIO_OP_LSB = 0;
    localparam int unsigned UIO_ACC    = 3;
    localparam int unsigned UIO_CLR    = 4;

    // ui_in operand B starts here
    localparam int unsigned B_LSB = 4;

    // Full-width bitwise op; callers slice down to their lane count.
    function automatic logic [LANE_MAX-1:0] logic_op(
        input logic [OP_W-1:0]     op,
        input logic [LANE_MAX-1:0] a,
        input logic [LANE_MAX-1:0] b
    );
        logic [LANE_MAX-1:0] r;
        case (op)
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            OP_NOTA:  r = ~a;
            OP_PASSA: r = a;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ihfaz_delay_line.sv
// WIDTH x DEPTH register chain with common enable and async active-low reset.
// o_last_d exposes the value the final stage will load on the next enabled
// edge, so the parent can detect changes without an extra register.
module ihfaz_delay_line
    import tt_ihfaz_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_last_d
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the chain on enabled edges; clear all stages on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_single
            assign o_last_d = i_d;
        end else begin : g_multi
            assign o_last_d = r_stage[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/tt_islam_ihfaz_logic_unit.sv
// LANES-wide registered bitwise logic unit with selectable op, accumulate
// feedback from the final pipeline stage and a result-change counter.
module tt_islam_ihfaz_logic_unit
    import tt_ihfaz_logic_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned PIPE  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CW = 8 - LANES;

    logic [LANES-1:0]    w_a;
    logic [LANES-1:0]    w_b_pin;
    logic [LANES-1:0]    w_b;
    logic [OP_W-1:0]     w_op;
    logic                w_acc;
    logic                w_clr;
    logic [LANE_MAX-1:0] w_a_full;
    logic [LANE_MAX-1:0] w_b_full;
    logic [LANE_MAX-1:0] w_f_full;
    logic [LANES-1:0]    w_f;
    logic [LANES-1:0]    w_result;
    logic [LANES-1:0]    w_result_next;
    logic [CW-1:0]       r_cnt;
    logic                w_unused;

    assign w_a     = ui_in[LANES-1:0];
    assign w_b_pin = ui_in[B_LSB +: LANES];
    assign w_op    = uio_in[UIO_OP_LSB +: OP_W];
    assign w_acc   = uio_in[UIO_ACC];
    assign w_clr   = uio_in[UIO_CLR];

    // Feedback select, then widen both operands to the op function width.
    always_comb begin
        w_b                  = w_acc ? w_result : w_b_pin;
        w_a_full             = '0;
        w_b_full             = '0;
        w_a_full[LANES-1:0]  = w_a;
        w_b_full[LANES-1:0]  = w_b;
        w_f_full             = logic_op(w_op, w_a_full, w_b_full);
        w_f                  = w_f_full[LANES-1:0];
    end

    ihfaz_delay_line #(
        .WIDTH (LANES),
        .DEPTH (PIPE)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (ena),
        .i_d      (w_f),
        .o_q      (w_result),
        .o_last_d (w_result_next)
    );

    // Count final-stage changes; clear wins over a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ena) begin
            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_result_next != w_result) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign uo_out  = {r_cnt, w_result};
    assign uio_out = '0;
    assign uio_oe  = '0;

    // Ignored pins and the unused upper op bits are deliberately dropped.
    assign w_unused = ^{ui_in, uio_in[7:5], w_f_full};

endmodule

// File: tb/tb_tt_islam_ihfaz_logic_unit.sv
// Directed bench for tt_islam_ihfaz_logic_unit: one PIPE=1 and one PIPE=3
// instance share all inputs; expected values are hand-computed constants.
module tb_tt_islam_ihfaz_logic_unit;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_p1, uio_out_p1, uio_oe_p1;
    logic [7:0] uo_p3, uio_out_p3, uio_oe_p3;

    int unsigned n_total;
    int unsigned n_bad;

    tt_islam_ihfaz_logic_unit #(.LANES(4), .PIPE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_p1), .uio_out(uio_out_p1), .uio_oe(uio_oe_p1)
    );

    tt_islam_ihfaz_logic_unit #(.LANES(4), .PIPE(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_p3), .uio_out(uio_out_p3), .uio_oe(uio_oe_p3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%02h exp=0x%02h", tag, got, exp);
        end
    endtask

    // Drive ui_in and uio_in fields {ign[7:5], clr, acc, op}
    task automatic drive(input logic [7:0] ui, input logic [2:0] op, input logic acc,
                         input logic clr, input logic [2:0] ign);
        ui_in  = ui;
        uio_in = {ign, clr, acc, op};
    endtask

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] op_exp [8];

    initial begin
        n_total = 0;
        n_bad   = 0;
        op_exp[0] = 8'h17; op_exp[1] = 8'h21; op_exp[2] = 8'h38; op_exp[3] = 8'h4E;
        op_exp[4] = 8'h56; op_exp[5] = 8'h69; op_exp[6] = 8'h75; op_exp[7] = 8'h8A;

        // Reset state
        rst_n = 1'b0;
        ena   = 1'b1;
        drive(8'h00, 3'b000, 1'b0, 1'b0, 3'b000);
        #12;
        chk("rst_p1", uo_p1, 8'h00);
        chk("rst_p3", uo_p3, 8'h00);
        chk("uio_out", uio_out_p1, 8'h00);
        chk("uio_oe", uio_oe_p1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // NAND A=C B=3 -> F, count 1; hold -> no change; FF -> 0, count 2
        drive(8'h3C, 3'b000, 1'b0, 1'b0, 3'b000);
        step();
        chk("nand_first", uo_p1, 8'h1F);
        step();
        chk("nand_hold", uo_p1, 8'h1F);
        drive(8'hFF, 3'b000, 1'b0, 1'b0, 3'b000);
        step();
        chk("nand_ff", uo_p1, 8'h20);

        // Clear count with result unchanged
        drive(8'hFF, 3'b000, 1'b0, 1'b1, 3'b000);
        step();
        chk("clr_cnt", uo_p1, 8'h00);

        // All ops A=A B=C, ignored uio bits set high
        for (int i = 0; i < 8; i++) begin
            drive(8'hCA, 3'(i), 1'b0, 1'b0, 3'b111);
            step();
            chk($sformatf("op%0d", i), uo_p1, op_exp[i]);
        end

        // Result 8A -> 0 with clr on the same edge: count stays 0
        drive(8'hFF, 3'b000, 1'b0, 1'b1, 3'b000);
        step();
        chk("clr_over_inc", uo_p1, 8'h00);

        // Accumulate XOR with A=1, B pins ignored: result toggles, count wraps
        drive(8'hF1, 3'b100, 1'b1, 1'b0, 3'b000);
        for (int n = 1; n <= 23; n++) begin
            step();
            if (n == 1 || n == 2 || n == 15 || n == 16 || n == 17 || n == 23)
                chk($sformatf("acc_%0d", n), uo_p1, {4'(n % 16), 4'(n % 2)});
        end

        // Async reset between edges at count 7
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_p1", uo_p1, 8'h00);
        chk("async_rst_p3", uo_p3, 8'h00);
        #1;
        rst_n = 1'b1;
        step();
        chk("acc_resume", uo_p1, 8'h11);

        // PIPE=3 latency: reset, settle on NAND FF -> 0, then step to 00
        rst_n = 1'b0;
        drive(8'hFF, 3'b000, 1'b0, 1'b0, 3'b000);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) step();
        chk("p3_settled", uo_p3, 8'h00);
        drive(8'h00, 3'b000, 1'b0, 1'b0, 3'b000);
        step();
        chk("p3_k", uo_p3, 8'h00);
        chk("p1_k", uo_p1, 8'h1F);
        step();
        chk("p3_k1", uo_p3, 8'h00);
        step();
        chk("p3_k2", uo_p3, 8'h1F);
        step();
        chk("p3_once", uo_p3, 8'h1F);

        // ena=0 freezes everything, clr ignored
        ena = 1'b0;
        for (int n = 0; n < 5; n++) begin
            drive(8'(8'h35 * (n + 1)), 3'(n), 1'(n % 2), 1'b1, 3'b000);
            step();
            chk($sformatf("frz_p1_%0d", n), uo_p1, 8'h1F);
            chk($sformatf("frz_p3_%0d", n), uo_p3, 8'h1F);
        end

        // Re-enable with clr and a result change on the same edge
        ena = 1'b1;
        drive(8'hFF, 3'b000, 1'b0, 1'b1, 3'b000);
        step();
        chk("ena_clr_p1", uo_p1, 8'h00);
        chk("ena_clr_p3", uo_p3, 8'h0F);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard stop in case the main sequence ever stalls
    initial begin
        #100000;
        n_bad++;
        $display("FAIL timeout: got=stalled exp=finished");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
